silife_controller: RTL and testbench

SILIFE_CONTROLLER -- requirements
Module: silife_controller

---
 rtl/silife_pkg.sv | 30 +++
 rtl/silife_tick_divider.sv | 28 ++
 rtl/silife_controller.sv | 173 +++++++++++++++++
 tb/tb_silife_controller.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/silife_pkg.sv
// Shared definitions for the silife controller: register map, control bit
// positions, FSM encoding and reset defaults.
package silife_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STEPS  = 3'd1;
  localparam logic [2:0] REG_PERIOD = 3'd2;
  localparam logic [2:0] REG_GEN    = 3'd3;
  localparam logic [2:0] REG_SCAN   = 3'd4;
  localparam logic [2:0] REG_IRQ    = 3'd5;
  localparam logic [2:0] REG_INFO   = 3'd6;
  localparam logic [2:0] REG_RSVD   = 3'd7;

  localparam int CTRL_RUN    = 0;
  localparam int CTRL_INVERT = 1;
  localparam int CTRL_PULSE  = 2;
  localparam int CTRL_WRAP   = 3;

  localparam int IRQ_DONE = 0;
  localparam int IRQ_EN   = 1;

  localparam logic [15:0] SCAN_RESET = 16'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FREE    = 2'd1,
    ST_COUNTED = 2'd2
  } state_e;

endpackage

// File: rtl/silife_tick_divider.sv
// Generation-period divider: counts enabled cycles and raises tick on the
// cycle the count matches period, then restarts from zero.
module silife_tick_divider #(
  parameter int PERIOD_BITS = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [PERIOD_BITS-1:0] period,
  output logic                   tick
);

  logic [PERIOD_BITS-1:0] cnt_q;

  // A clearing cycle never ticks, so a restart always waits period+1 cycles.
  assign tick = enable & ~clear & (cnt_q == period);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      if (cnt_q == period) cnt_q <= '0;
      else                 cnt_q <= cnt_q + PERIOD_BITS'(1);
    end
  end

endmodule

// File: rtl/silife_controller.sv
// Wishbone-controlled run/step sequencer for the silife matrix: issues
// gen_step pulses in free-running or counted mode and counts generations.
module silife_controller
  import silife_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int HEIGHT      = 8,
  parameter int PERIOD_BITS = 16,
  parameter int GEN_BITS    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_data,
  output logic        gen_step,
  output logic        invert,
  output logic        wrap,
  output logic        running,
  output logic [15:0] scan_cycles,
  output logic        irq
);

  state_e                 state_q;
  logic [31:0]            steps_q;
  logic [PERIOD_BITS-1:0] period_q;
  logic [GEN_BITS-1:0]    gen_q;
  logic [15:0]            scan_q;
  logic                   invert_q;
  logic                   wrap_q;
  logic                   done_q;
  logic                   irq_en_q;
  logic                   ack_q;
  logic [31:0]            rdata_q;
  logic [31:0]            rdata_d;
  logic                   gen_step_q;

  logic       acc;
  logic       wr;
  logic [2:0] addr;
  logic       wr_ctrl, wr_steps, wr_period, wr_gen, wr_scan, wr_irq;
  logic       w_run;
  logic       steps_nz;
  logic       pulse_fire;
  logic       enter_run;
  logic       div_clear;
  logic       tick;
  logic       step;
  logic       unused_addr;

  assign unused_addr = ^{i_wb_addr[31:5], i_wb_addr[1:0]};

  assign acc       = i_wb_cyc & i_wb_stb & ~ack_q;
  assign wr        = acc & i_wb_we;
  assign addr      = i_wb_addr[4:2];
  assign wr_ctrl   = wr && (addr == REG_CTRL);
  assign wr_steps  = wr && (addr == REG_STEPS);
  assign wr_period = wr && (addr == REG_PERIOD);
  assign wr_gen    = wr && (addr == REG_GEN);
  assign wr_scan   = wr && (addr == REG_SCAN);
  assign wr_irq    = wr && (addr == REG_IRQ);
  assign w_run     = i_wb_data[CTRL_RUN];
  assign steps_nz  = |i_wb_data;

  assign pulse_fire = wr_ctrl && i_wb_data[CTRL_PULSE] && (state_q == ST_IDLE);
  assign enter_run  = (wr_steps && steps_nz) || (wr_ctrl && w_run && (state_q == ST_IDLE));
  assign div_clear  = enter_run | wr_period;
  assign step       = tick | pulse_fire;

  silife_tick_divider #(
    .PERIOD_BITS(PERIOD_BITS)
  ) u_div (
    .clk    (clk),
    .reset  (reset),
    .enable (state_q != ST_IDLE),
    .clear  (div_clear),
    .period (period_q),
    .tick   (tick)
  );

  always_comb begin
    rdata_d = '0;
    case (addr)
      REG_CTRL: begin
        rdata_d[CTRL_RUN]    = (state_q != ST_IDLE);
        rdata_d[CTRL_INVERT] = invert_q;
        rdata_d[CTRL_WRAP]   = wrap_q;
      end
      REG_STEPS:  rdata_d = steps_q;
      REG_PERIOD: rdata_d = 32'(period_q);
      REG_GEN:    rdata_d = 32'(gen_q);
      REG_SCAN:   rdata_d = 32'(scan_q);
      REG_IRQ: begin
        rdata_d[IRQ_DONE] = done_q;
        rdata_d[IRQ_EN]   = irq_en_q;
      end
      REG_INFO:   rdata_d = {16'd0, 8'(HEIGHT), 8'(WIDTH)};
      default:    rdata_d = '0;
    endcase
  end

  // Later assignments to done_q win, so a completing run beats an IRQ clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      steps_q    <= '0;
      period_q   <= '0;
      gen_q      <= '0;
      scan_q     <= SCAN_RESET;
      invert_q   <= 1'b0;
      wrap_q     <= 1'b0;
      done_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      gen_step_q <= 1'b0;
    end else begin
      ack_q      <= acc;
      gen_step_q <= step;
      if (acc && !i_wb_we) rdata_q <= rdata_d;

      if (wr_gen)    gen_q <= i_wb_data[GEN_BITS-1:0];
      else if (step) gen_q <= gen_q + GEN_BITS'(1);

      if (wr_ctrl) begin
        invert_q <= i_wb_data[CTRL_INVERT];
        wrap_q   <= i_wb_data[CTRL_WRAP];
      end
      if (wr_period) period_q <= i_wb_data[PERIOD_BITS-1:0];
      if (wr_scan)   scan_q   <= (i_wb_data[15:0] == 16'd0) ? 16'd1 : i_wb_data[15:0];
      if (wr_irq) begin
        if (i_wb_data[IRQ_DONE]) done_q <= 1'b0;
        irq_en_q <= i_wb_data[IRQ_EN];
      end

      if (wr_steps) begin
        steps_q <= i_wb_data;
        state_q <= steps_nz ? ST_COUNTED : ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: if (wr_ctrl && w_run) state_q <= ST_FREE;
          ST_FREE: if (wr_ctrl && !w_run) state_q <= ST_IDLE;
          ST_COUNTED: begin
            if (wr_ctrl && !w_run) begin
              state_q <= ST_IDLE;
            end else if (tick) begin
              steps_q <= steps_q - 32'd1;
              if (steps_q == 32'd1) begin
                state_q <= ST_IDLE;
                done_q  <= 1'b1;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_wb_ack    = ack_q;
  assign o_wb_data   = rdata_q;
  assign gen_step    = gen_step_q;
  assign invert      = invert_q;
  assign wrap        = wrap_q;
  assign running     = (state_q != ST_IDLE);
  assign scan_cycles = scan_q;
  assign irq         = done_q & irq_en_q;

endmodule

// File: tb/tb_silife_controller.sv
// Self-checking bench for silife_controller: register reads go through a
// scoreboard queue, gen_step pulses are logged by cycle number.
module tb_silife_controller;

  localparam logic [2:0] A_CTRL = 3'd0, A_STEPS = 3'd1, A_PERIOD = 3'd2, A_GEN = 3'd3;
  localparam logic [2:0] A_SCAN = 3'd4, A_IRQ = 3'd5, A_INFO = 3'd6, A_RSVD = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [31:0] wb_addr = '0, wb_wdata = '0;
  logic        wb_ack;
  logic [31:0] wb_rdata;
  logic        gen_step, invert, wrap, running, irq;
  logic [15:0] scan_cycles;

  typedef struct {
    string       name;
    logic [31:0] val;
    logic [2:0]  addr;
  } rd_exp_t;

  rd_exp_t sb[$];
  int      pulse_log[$];
  int      exp_pulses[$];
  int      checks = 0;
  int      passes = 0;
  int      cyc_cnt = 0;

  silife_controller dut (
    .clk         (clk),
    .reset       (reset),
    .i_wb_cyc    (wb_cyc),
    .i_wb_stb    (wb_stb),
    .i_wb_we     (wb_we),
    .i_wb_addr   (wb_addr),
    .i_wb_data   (wb_wdata),
    .o_wb_ack    (wb_ack),
    .o_wb_data   (wb_rdata),
    .gen_step    (gen_step),
    .invert      (invert),
    .wrap        (wrap),
    .running     (running),
    .scan_cycles (scan_cycles),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(posedge clk) begin
    #1;
    if (gen_step === 1'b1) pulse_log.push_back(cyc_cnt);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wb_xfer(input logic we, input logic [2:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output int acc);
    int n;
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
    wb_addr = {27'd0, a, 2'b00}; wb_wdata = d;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (wb_ack !== 1'b1 && n < 8);
    if (wb_ack !== 1'b1) begin
      checks++;
      $display("FAIL ack_timeout: no ack for addr %0d after %0d cycles", a, n);
    end
    rd = wb_rdata;
    acc = cyc_cnt;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [31:0] d, output int acc);
    logic [31:0] rd;
    wb_xfer(1'b1, a, d, rd, acc);
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [31:0] rd);
    int acc;
    wb_xfer(1'b0, a, 32'd0, rd, acc);
  endtask

  task automatic test_reset;
    rd_exp_t     e;
    logic [31:0] rd;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({wb_ack, gen_step, irq, running, invert, wrap} !== 6'b0)
      $display("FAIL reset_flags: got %b expected 000000", {wb_ack, gen_step, irq, running, invert, wrap});
    else passes++;
    checks++;
    if (scan_cycles !== 16'd3) $display("FAIL reset_scan: got %0d expected 3", scan_cycles);
    else passes++;
    checks++;
    if (wb_rdata !== 32'd0) $display("FAIL reset_rdata: got %h expected 0", wb_rdata);
    else passes++;
    @(negedge clk);
    reset = 1'b0;
    // ack must rise exactly one cycle after the strobe and last one cycle
    sb.push_back('{"info_first", 32'h0000_0808, A_INFO});
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = {27'd0, A_INFO, 2'b00};
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (wb_ack !== 1'b1 || wb_rdata !== e.val)
      $display("FAIL %s: ack=%b data=%h, expected ack=1 data=%h", e.name, wb_ack, wb_rdata, e.val);
    else passes++;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (wb_ack !== 1'b0) $display("FAIL ack_single: ack=%b expected 0", wb_ack);
    else passes++;
    sb.push_back('{"rst_scan", 32'd3, A_SCAN});
    sb.push_back('{"rst_steps", 32'd0, A_STEPS});
    sb.push_back('{"rst_period", 32'd0, A_PERIOD});
    sb.push_back('{"rst_gen", 32'd0, A_GEN});
    sb.push_back('{"rst_irq", 32'd0, A_IRQ});
    sb.push_back('{"rst_rsvd", 32'd0, A_RSVD});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wb_read(e.addr, rd);
      checks++;
      if (rd !== e.val) $display("FAIL %s: read %h expected %h", e.name, rd, e.val);
      else passes++;
    end
  endtask

  task automatic test_counted;
    rd_exp_t     e;
    logic [31:0] rd;
    int          acc, obs;
    wb_write(A_PERIOD, 32'd4, acc);
    pulse_log.delete();
    exp_pulses.delete();
    wb_write(A_STEPS, 32'd3, acc);
    for (int k = 1; k <= 3; k++) exp_pulses.push_back(acc + 5 * k);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (pulse_log.size() != exp_pulses.size())
      $display("FAIL counted_npulses: got %0d expected %0d", pulse_log.size(), exp_pulses.size());
    else passes++;
    for (int i = 0; i < exp_pulses.size(); i++) begin
      obs = (i < pulse_log.size()) ? pulse_log[i] : -1;
      checks++;
      if (obs != exp_pulses[i]) $display("FAIL counted_pulse%0d: cycle %0d expected %0d", i, obs, exp_pulses[i]);
      else passes++;
    end
    checks++;
    if (running !== 1'b0 || irq !== 1'b0)
      $display("FAIL counted_end: running=%b irq=%b expected 0 0", running, irq);
    else passes++;
    sb.push_back('{"counted_gen", 32'd3, A_GEN});
    sb.push_back('{"counted_steps", 32'd0, A_STEPS});
    sb.push_back('{"counted_irq", 32'd1, A_IRQ});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wb_read(e.addr, rd);
      checks++;
      if (rd !== e.val) $display("FAIL %s: read %h expected %h", e.name, rd, e.val);
      else passes++;
    end
  endtask

  task automatic test_irq;
    rd_exp_t     e;
    logic [31:0] rd;
    int          acc;
    wb_write(A_IRQ, 32'h3, acc);
    checks++;
    if (irq !== 1'b0) $display("FAIL irq_cleared: irq=%b expected 0", irq);
    else passes++;
    wb_write(A_PERIOD, 32'd0, acc);
    wb_write(A_STEPS, 32'd1, acc);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b1) $display("FAIL irq_raised: irq=%b expected 1", irq);
    else passes++;
    wb_write(A_IRQ, 32'h3, acc);
    checks++;
    if (irq !== 1'b0) $display("FAIL irq_ack: irq=%b expected 0", irq);
    else passes++;
    sb.push_back('{"irq_en_kept", 32'h2, A_IRQ});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wb_read(e.addr, rd);
      checks++;
      if (rd !== e.val) $display("FAIL %s: read %h expected %h", e.name, rd, e.val);
      else passes++;
    end
  endtask

  task automatic test_gen_wrap;
    rd_exp_t     e;
    logic [31:0] rd;
    int          acc, obs;
    wb_write(A_GEN, 32'hFFFF_FFFF, acc);
    wb_write(A_PERIOD, 32'd0, acc);
    pulse_log.delete();
    wb_write(A_CTRL, 32'h4, acc);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (pulse_log.size() != 1) $display("FAIL pulse_count: got %0d expected 1", pulse_log.size());
    else passes++;
    obs = (pulse_log.size() > 0) ? pulse_log[0] : -1;
    checks++;
    if (obs != acc) $display("FAIL pulse_cycle: cycle %0d expected %0d", obs, acc);
    else passes++;
    sb.push_back('{"gen_wrapped", 32'd0, A_GEN});
    sb.push_back('{"ctrl_pulse_rd0", 32'd0, A_CTRL});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wb_read(e.addr, rd);
      checks++;
      if (rd !== e.val) $display("FAIL %s: read %h expected %h", e.name, rd, e.val);
      else passes++;
    end
  endtask

  task automatic test_regs;
    rd_exp_t     e;
    logic [31:0] rd;
    int          acc;
    wb_write(A_CTRL, 32'hA, acc);
    checks++;
    if ({invert, wrap, running} !== 3'b110)
      $display("FAIL ctrl_outputs: got %b expected 110", {invert, wrap, running});
    else passes++;
    wb_write(A_SCAN, 32'd0, acc);
    checks++;
    if (scan_cycles !== 16'd1) $display("FAIL scan_zero: got %0d expected 1", scan_cycles);
    else passes++;
    wb_write(A_SCAN, 32'h1234, acc);
    wb_write(A_INFO, 32'hFFFF_FFFF, acc);
    wb_write(A_RSVD, 32'hFFFF_FFFF, acc);
    sb.push_back('{"ctrl_rd", 32'hA, A_CTRL});
    sb.push_back('{"scan_rd", 32'h1234, A_SCAN});
    sb.push_back('{"info_ro", 32'h0000_0808, A_INFO});
    sb.push_back('{"rsvd_rd", 32'd0, A_RSVD});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wb_read(e.addr, rd);
      checks++;
      if (rd !== e.val) $display("FAIL %s: read %h expected %h", e.name, rd, e.val);
      else passes++;
    end
    wb_write(A_CTRL, 32'h0, acc);
  endtask

  task automatic test_free_then_steps;
    rd_exp_t     e;
    logic [31:0] rd;
    int          a1, a2, obs;
    wb_write(A_PERIOD, 32'd0, a1);
    pulse_log.delete();
    exp_pulses.delete();
    wb_write(A_CTRL, 32'h1, a1);
    repeat (3) @(posedge clk);
    wb_write(A_STEPS, 32'd2, a2);
    for (int c = a1 + 1; c < a2; c++) exp_pulses.push_back(c);
    exp_pulses.push_back(a2 + 1);
    exp_pulses.push_back(a2 + 2);
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (pulse_log.size() != exp_pulses.size())
      $display("FAIL free_npulses: got %0d expected %0d", pulse_log.size(), exp_pulses.size());
    else passes++;
    for (int i = 0; i < exp_pulses.size(); i++) begin
      obs = (i < pulse_log.size()) ? pulse_log[i] : -1;
      checks++;
      if (obs != exp_pulses[i]) $display("FAIL free_pulse%0d: cycle %0d expected %0d", i, obs, exp_pulses[i]);
      else passes++;
    end
    checks++;
    if (running !== 1'b0 || irq !== 1'b1)
      $display("FAIL free_end: running=%b irq=%b expected 0 1", running, irq);
    else passes++;
    sb.push_back('{"free_gen", 32'(exp_pulses.size()), A_GEN});
    sb.push_back('{"free_steps", 32'd0, A_STEPS});
    sb.push_back('{"free_irq", 32'h3, A_IRQ});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wb_read(e.addr, rd);
      checks++;
      if (rd !== e.val) $display("FAIL %s: read %h expected %h", e.name, rd, e.val);
      else passes++;
    end
  endtask

  task automatic test_abort;
    rd_exp_t     e;
    logic [31:0] rd;
    int          acc;
    wb_write(A_PERIOD, 32'd100, acc);
    wb_write(A_CTRL, 32'h1, acc);
    checks++;
    if (running !== 1'b1) $display("FAIL free_start: running=%b expected 1", running);
    else passes++;
    wb_write(A_CTRL, 32'h0, acc);
    checks++;
    if (running !== 1'b0) $display("FAIL free_stop: running=%b expected 0", running);
    else passes++;
    wb_write(A_STEPS, 32'd5, acc);
    checks++;
    if (running !== 1'b1) $display("FAIL counted_start: running=%b expected 1", running);
    else passes++;
    wb_write(A_STEPS, 32'd0, acc);
    checks++;
    if (running !== 1'b0) $display("FAIL steps0_idle: running=%b expected 0", running);
    else passes++;
    sb.push_back('{"steps0_steps", 32'd0, A_STEPS});
    sb.push_back('{"steps0_done_kept", 32'h3, A_IRQ});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wb_read(e.addr, rd);
      checks++;
      if (rd !== e.val) $display("FAIL %s: read %h expected %h", e.name, rd, e.val);
      else passes++;
    end
  endtask

  task automatic test_reset_mid_run;
    rd_exp_t     e;
    logic [31:0] rd;
    int          acc;
    wb_write(A_PERIOD, 32'd0, acc);
    wb_write(A_STEPS, 32'd1000, acc);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (running !== 1'b1 || gen_step !== 1'b1)
      $display("FAIL midrun_active: running=%b gen_step=%b expected 1 1", running, gen_step);
    else passes++;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({gen_step, running, irq, wb_ack} !== 4'b0)
      $display("FAIL midrun_reset: got %b expected 0000", {gen_step, running, irq, wb_ack});
    else passes++;
    @(negedge clk);
    reset = 1'b0;
    sb.push_back('{"midrun_steps", 32'd0, A_STEPS});
    sb.push_back('{"midrun_gen", 32'd0, A_GEN});
    sb.push_back('{"midrun_period", 32'd0, A_PERIOD});
    sb.push_back('{"midrun_irq", 32'd0, A_IRQ});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wb_read(e.addr, rd);
      checks++;
      if (rd !== e.val) $display("FAIL %s: read %h expected %h", e.name, rd, e.val);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_counted();
    test_irq();
    test_gen_wrap();
    test_regs();
    test_free_then_steps();
    test_abort();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
